// File: rtl/fetch_decode.sv
// Fetch/decode front end: small instruction memory, PC, instruction register
// and a four-state sequencer that issues decoded fields with a ready handshake.
module fetch_decode #(
    parameter int PC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                prog_we,
    input  logic [PC_WIDTH-1:0] prog_addr,
    input  logic [7:0]          prog_data,
    input  logic                start,
    input  logic                exec_ready,
    output logic [1:0]          op_code,
    output logic [1:0]          dest_addr,
    output logic [1:0]          src_addr1,
    output logic [1:0]          src_addr2,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] OP_HALT = 2'b11;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic                prime_q, prime_d;
    logic                mem_we;
    logic                is_halt_op;

    logic [7:0] imem [2**PC_WIDTH];

    assign mem_we     = prog_we && (state_q == S_IDLE || state_q == S_HALT);
    assign is_halt_op = (ir_q[7:6] == OP_HALT);

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        prime_d = prime_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    prime_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // First fetch after start waits one cycle for write turnaround.
                if (prime_q) begin
                    prime_d = 1'b0;
                end else begin
                    ir_d    = imem[pc_q];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_halt_op) begin
                    state_d = S_HALT;
                end else if (exec_ready) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            prime_q <= prime_d;
        end
    end

    assign op_code     = ir_q[7:6];
    assign dest_addr   = ir_q[5:4];
    assign src_addr1   = ir_q[3:2];
    assign src_addr2   = ir_q[1:0];
    assign instr_valid = (state_q == S_ISSUE) && !is_halt_op;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);

endmodule
